// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq -- command sequencer feeding a W-bit JK flip-flop bank.
//
// Commands (op, mask, rep) arrive over a valid/ready handshake and wait in a
// DEPTH-entry FIFO. The FSM pops one command at a time. For rep+1 cycles it
// drives per-bit J/K/E from that command, then pulses done for one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   cmd_valid  command present on cmd_op/cmd_mask/cmd_rep
//   cmd_ready  FIFO not full; accept on cmd_valid && cmd_ready
//   cmd_op     00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   cmd_mask   bits the command acts on
//   cmd_rep    number of apply cycles minus one
//   J, K, E    per-bit drive to the bank
//   busy       high while applying or signalling done
//   done       one-cycle pulse after the last apply cycle
//
// Optional build macro JK_CMD_VERIFY_EN adds:
//   q_obs      observed bank Q outputs
//   err        sticky: set when the bank state at DONE differs from the
//              state the command should have produced; cleared by reset
//
// State table:
//   S_IDLE  | outputs idle; pop FIFO head when available
//   S_APPLY | drive J/K/E from op_r/mask_r for cnt_r+1 cycles
//   S_DONE  | outputs idle; done=1 for one cycle

module jk_cmd_seq #(
    parameter int W     = 4,
    parameter int CNT_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_mask,
    input  logic [CNT_W-1:0] cmd_rep,
`ifdef JK_CMD_VERIFY_EN
    input  logic [W-1:0]     q_obs,
    output logic             err,
`endif
    output logic [W-1:0]     J,
    output logic [W-1:0]     K,
    output logic [W-1:0]     E,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + W + CNT_W;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // FIFO storage; pointers carry one extra wrap bit to tell full from empty
    logic [EW-1:0]    mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic [1:0]       head_op;
    logic [W-1:0]     head_mask;
    logic [CNT_W-1:0] head_rep;

    state_t           state_r;
    state_t           state_nx;
    logic [1:0]       op_r;
    logic [W-1:0]     mask_r;
    logic [CNT_W-1:0] cnt_r;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_op   = head[EW-1 -: 2];
    assign head_mask = head[CNT_W +: W];
    assign head_rep  = head[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_mask, cmd_rep};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nx = state_r;
        pop      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_APPLY;
                end
            end
            S_APPLY: begin
                if (cnt_r == '0) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            op_r    <= OP_HOLD;
            mask_r  <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx;
            if (pop) begin
                op_r   <= head_op;
                mask_r <= head_mask;
                cnt_r  <= head_rep;
            end else if (state_r == S_APPLY) begin
                cnt_r  <= cnt_r - 1'b1;
            end
        end
    end

    always_comb begin
        J    = '0;
        K    = '0;
        E    = '0;
        busy = (state_r != S_IDLE);
        done = (state_r == S_DONE);
        if (state_r == S_APPLY) begin
            E = mask_r;
            J = mask_r & {W{op_r[1]}};
            K = mask_r & {W{(op_r == OP_RESET) || (op_r == OP_TOGGLE)}};
        end
    end

`ifdef JK_CMD_VERIFY_EN
    logic [W-1:0] q0_r;
    logic         rep0_r;
    logic         err_r;
    logic [W-1:0] q_exp;

    // TOGGLE flips the bank rep+1 times: net inversion only when rep is even
    always_comb begin
        q_exp = q0_r;
        case (op_r)
            OP_RESET:  q_exp = '0;
            OP_SET:    q_exp = '1;
            OP_TOGGLE: q_exp = q0_r ^ {W{~rep0_r}};
            default:   q_exp = q0_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q0_r   <= '0;
            rep0_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (pop) begin
                q0_r   <= q_obs;
                rep0_r <= head_rep[0];
            end
            if ((state_r == S_DONE) && (((q_obs ^ q_exp) & mask_r) != '0)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq. The reference model is a schedule:
// each accepted command gets a pop cycle computed from its accept cycle and
// the first free IDLE cycle of the sequencer. All expected outputs of a
// cycle are then derived from that schedule.
module tb_jk_cmd_seq;

    localparam int W     = 4;
    localparam int CNT_W = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [W-1:0]     cmd_mask;
    logic [CNT_W-1:0] cmd_rep;
    logic [W-1:0]     J, K, E;
    logic             busy, done;

`ifdef JK_CMD_VERIFY_EN
    logic [W-1:0] q_obs;
    logic         err;
    logic [W-1:0] q_bank = '0;
    logic         corrupt = 1'b0;
    assign q_obs = q_bank ^ {{(W-1){1'b0}}, corrupt};

    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (E[i]) begin
                case ({J[i], K[i]})
                    2'b01:   q_bank[i] <= 1'b0;
                    2'b10:   q_bank[i] <= 1'b1;
                    2'b11:   q_bank[i] <= ~q_bank[i];
                    default: q_bank[i] <= q_bank[i];
                endcase
            end
        end
    end
`endif

    jk_cmd_seq #(.W(W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_rep   (cmd_rep),
`ifdef JK_CMD_VERIFY_EN
        .q_obs     (q_obs),
        .err       (err),
`endif
        .J         (J),
        .K         (K),
        .E         (E),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] mask;
        int           rep;
        int           t;   // accept cycle
        int           p;   // pop cycle
    } cmd_t;

    cmd_t sched[$];
    int   cyc     = 0;
    int   free    = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    logic err_exp = 1'b0;

    // A command popped in cycle p applies in p+1..p+1+rep, signals done in
    // p+2+rep; the sequencer may pop again in p+3+rep.
    function automatic void expect_at(input int c,
                                      output logic [W-1:0] ej, output logic [W-1:0] ek,
                                      output logic [W-1:0] ee, output logic eb,
                                      output logic ed, output logic er);
        int occ;
        ej = '0; ek = '0; ee = '0; eb = 1'b0; ed = 1'b0; occ = 0;
        foreach (sched[i]) begin
            if (c > sched[i].p && c <= sched[i].p + 1 + sched[i].rep) begin
                eb = 1'b1;
                ee = sched[i].mask;
                case (sched[i].op)
                    2'b01:   ek = sched[i].mask;
                    2'b10:   ej = sched[i].mask;
                    2'b11:   begin ej = sched[i].mask; ek = sched[i].mask; end
                    default: ;
                endcase
            end
            if (c == sched[i].p + 2 + sched[i].rep) begin
                eb = 1'b1;
                ed = 1'b1;
            end
            if (sched[i].t < c && sched[i].p >= c) occ++;
        end
        er = (occ < DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Called at the falling edge inside cycle cyc: check, drive, advance.
    task automatic step(input logic v, input logic [1:0] op, input logic [W-1:0] m,
                        input logic [CNT_W-1:0] r, input logic rst);
        logic [W-1:0] ej, ek, ee;
        logic         eb, ed, er;
        cmd_t         c;
        int           p;
        expect_at(cyc, ej, ek, ee, eb, ed, er);
        chk("J", J, ej);
        chk("K", K, ek);
        chk("E", E, ee);
        chk("busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, eb});
        chk("done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, ed});
        chk("cmd_ready", {{(W-1){1'b0}}, cmd_ready}, {{(W-1){1'b0}}, er});
`ifdef JK_CMD_VERIFY_EN
        chk("err", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, err_exp});
`endif
        cmd_valid = v;
        cmd_op    = op;
        cmd_mask  = m;
        cmd_rep   = r;
        reset     = rst;
        if (v && er && !rst) begin
            p      = (cyc + 1 > free) ? cyc + 1 : free;
            c.op   = op;
            c.mask = m;
            c.rep  = int'(r);
            c.t    = cyc;
            c.p    = p;
            sched.push_back(c);
            free   = p + 3 + int'(r);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            sched.delete();
            free    = 0;
            err_exp = 1'b0;
        end
        while (sched.size() > 0 && sched[0].p + 2 + sched[0].rep < cyc) void'(sched.pop_front());
        @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sched.size() > 0 && k < 400) begin
            idle(1);
            k++;
        end
        idle(2);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_mask  = '0;
        cmd_rep   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;

        // reset state, then SET 1111 rep=3
        idle(1);
        step(1'b1, 2'b10, 4'b1111, 4'd3, 1'b0);
        idle(8);

        // RESET 0101 rep=0 followed by TOGGLE 1111 rep=1
        step(1'b1, 2'b01, 4'b0101, 4'd0, 1'b0);
        step(1'b1, 2'b11, 4'b1111, 4'd1, 1'b0);
        drain();

        // long APPLY while the FIFO fills; extra valids must be refused
        step(1'b1, 2'b10, 4'b0011, 4'd15, 1'b0);
        for (int i = 0; i < 30; i++)
            step(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 1'b0);
        drain();

        // reset in the third apply cycle of SET rep=7, with another queued
        step(1'b1, 2'b10, 4'b1111, 4'd7, 1'b0);
        step(1'b1, 2'b11, 4'b1010, 4'd2, 1'b0);
        idle(2);
        step(1'b0, 2'b00, '0, '0, 1'b1);
        idle(12);
        step(1'b1, 2'b01, 4'b0110, 4'd1, 1'b0);
        drain();

        // mask=0 with maximum repeat count
        step(1'b1, 2'b00, 4'b0000, 4'd15, 1'b0);
        drain();

        // maximum repeat with full mask
        step(1'b1, 2'b11, 4'b1111, 4'd15, 1'b0);
        drain();

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)),
                 ($urandom_range(0, 149) == 0));
        drain();

`ifdef JK_CMD_VERIFY_EN
        begin
            int d;
            int k;
            step(1'b1, 2'b01, 4'b1111, 4'd0, 1'b0);
            drain();
            chk("q_clear", q_bank, 4'b0000);
            step(1'b1, 2'b11, 4'b1111, 4'd2, 1'b0);
            drain();
            chk("q_toggle", q_bank, 4'b1111);
            step(1'b1, 2'b10, 4'b0001, 4'd0, 1'b0);
            d = sched[$].p + 2;
            k = 0;
            while (cyc < d && k < 20) begin
                idle(1);
                k++;
            end
            corrupt = 1'b1;
            idle(1);
            corrupt = 1'b0;
            err_exp = 1'b1;
            idle(6);
            step(1'b0, 2'b00, '0, '0, 1'b1);
            idle(3);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
